// File: rtl/int_req_multi.sv
// ---------------------------------------------------------------------------
// int_req_multi: parametrised interrupt request register (IRR).
// The IR pins are synchronised, then captured per channel in level or edge
// mode. While frozen, edges are parked in a pending latch so they are not
// lost. A sticky per-channel flag records edges that were absorbed by an
// already-set request.
//
// Ports:
//   clock                       system clock, rising edge
//   reset                       synchronous, active-high
//   level_triggered_config      per channel: 1 = level mode, 0 = edge mode
//   freeze                      IRR holds (pending capture stays active)
//   clear_interrupt_request     per-channel IRR clear (multi-hot allowed)
//   overflow_clear              per-channel clear of edge_overflow
//   interrupt_request_pin       asynchronous IR pins
//   interrupt_request_register  IRR
//   edge_overflow               sticky missed-edge flags
//   any_request                 OR-reduction of IRR
// ---------------------------------------------------------------------------
module int_req_multi #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] level_triggered_config,
    input  logic               freeze,
    input  logic [NUM_IRQ-1:0] clear_interrupt_request,
    input  logic [NUM_IRQ-1:0] overflow_clear,
    input  logic [NUM_IRQ-1:0] interrupt_request_pin,
    output logic [NUM_IRQ-1:0] interrupt_request_register,
    output logic [NUM_IRQ-1:0] edge_overflow,
    output logic               any_request
);

    localparam logic [1:0] FILL_MAX = 2'(SYNC_STAGES);

    logic [1:0]         fill_cnt;
    logic               sync_valid;
    logic [NUM_IRQ-1:0] pin_s;
    logic [NUM_IRQ-1:0] pin_prev;
    logic [NUM_IRQ-1:0] cfg_q;
    logic [NUM_IRQ-1:0] pending;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] edge_mode;
    logic [NUM_IRQ-1:0] cfg_change;
    logic [NUM_IRQ-1:0] freeze_v;
    logic [NUM_IRQ-1:0] level_val;
    logic [NUM_IRQ-1:0] irr_run;
    logic [NUM_IRQ-1:0] irr_d;
    logic [NUM_IRQ-1:0] pend_set;
    logic [NUM_IRQ-1:0] pend_fold;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] ovf_set;
    logic [NUM_IRQ-1:0] ovf_d;

    // Fill counter: synchroniser output is trusted only once every stage
    // has been loaded from a post-reset pin sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            fill_cnt <= 2'd0;
        end else if (!sync_valid) begin
            fill_cnt <= fill_cnt + 2'd1;
        end
    end

    assign sync_valid = (fill_cnt == FILL_MAX);

    // Pin synchroniser chain
    if (SYNC_STAGES == 0) begin : g_nosync
        assign pin_s = interrupt_request_pin;
    end else begin : g_sync
        logic [NUM_IRQ-1:0] stage [SYNC_STAGES];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int unsigned j = 0; j < SYNC_STAGES; j++) begin
                    stage[j] <= '0;
                end
            end else begin
                stage[0] <= interrupt_request_pin;
                for (int unsigned j = 1; j < SYNC_STAGES; j++) begin
                    stage[j] <= stage[j-1];
                end
            end
        end

        assign pin_s = stage[SYNC_STAGES-1];
    end

    // Next-state logic for IRR, pending latch and overflow flags
    always_comb begin
        freeze_v   = {NUM_IRQ{freeze}};
        edge_mode  = ~level_triggered_config;
        cfg_change = level_triggered_config ^ cfg_q;
        // pin_prev resets to ones so a pin high through reset is not an edge
        rise       = {NUM_IRQ{sync_valid}} & pin_s & ~pin_prev;
        level_val  = sync_valid ? pin_s : '0;

        irr_run = (level_triggered_config & level_val)
                | (edge_mode & (interrupt_request_register | rise | pending));
        // clear beats freeze, freeze beats normal capture
        irr_d   = (freeze ? interrupt_request_register : irr_run)
                & ~clear_interrupt_request;

        // Park edges that IRR cannot take this cycle; fold them in later
        pend_set  = rise & (freeze_v | clear_interrupt_request);
        pend_fold = ~freeze_v & ~clear_interrupt_request;
        pend_d    = edge_mode & ~cfg_change
                  & (pend_set | (pending & ~pend_fold));

        // Edge absorbed by an already-set request or an already-parked edge
        ovf_set = rise & ((edge_mode & interrupt_request_register
                           & ~clear_interrupt_request) | pending);
        ovf_d   = ovf_set | (edge_overflow & ~overflow_clear);
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pin_prev                   <= '1;
            cfg_q                      <= '0;
            pending                    <= '0;
            interrupt_request_register <= '0;
            edge_overflow              <= '0;
        end else begin
            if (sync_valid) begin
                pin_prev <= pin_s;
            end
            cfg_q                      <= level_triggered_config;
            pending                    <= pend_d;
            interrupt_request_register <= irr_d;
            edge_overflow              <= ovf_d;
        end
    end

    assign any_request = |interrupt_request_register;

endmodule

// File: tb/tb_int_req_multi.sv
// ---------------------------------------------------------------------------
// Bench for int_req_multi. Two instances share one stimulus:
//   dut_a: NUM_IRQ=8,  SYNC_STAGES=2
//   dut_b: NUM_IRQ=16, SYNC_STAGES=0
// A behavioural model derives pin_s / pin_prev from a history of sampled pin
// values and applies the per-channel rules; outputs are compared every
// falling edge. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_int_req_multi;

    logic        clock;
    logic        reset;
    logic [31:0] cfg;
    logic        frz;
    logic [31:0] clr;
    logic [31:0] oclr;
    logic [31:0] pin;

    logic [7:0]  a_irr, a_ovf;
    logic        a_any;
    logic [15:0] b_irr, b_ovf;
    logic        b_any;

    int total = 0;
    int bad   = 0;

    int_req_multi #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut_a (
        .clock                      (clock),
        .reset                      (reset),
        .level_triggered_config     (cfg[7:0]),
        .freeze                     (frz),
        .clear_interrupt_request    (clr[7:0]),
        .overflow_clear             (oclr[7:0]),
        .interrupt_request_pin      (pin[7:0]),
        .interrupt_request_register (a_irr),
        .edge_overflow              (a_ovf),
        .any_request                (a_any)
    );

    int_req_multi #(.NUM_IRQ(16), .SYNC_STAGES(0)) dut_b (
        .clock                      (clock),
        .reset                      (reset),
        .level_triggered_config     (cfg[15:0]),
        .freeze                     (frz),
        .clear_interrupt_request    (clr[15:0]),
        .overflow_clear             (oclr[15:0]),
        .interrupt_request_pin      (pin[15:0]),
        .interrupt_request_register (b_irr),
        .edge_overflow              (b_ovf),
        .any_request                (b_any)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[j] = pin value sampled j edges ago (hist[0] = this edge)
    logic [31:0] hist [4];
    int          m_n;
    logic [31:0] m_cfgp;
    logic [31:0] m_irr  [2];
    logic [31:0] m_pend [2];
    logic [31:0] m_ovf  [2];
    logic        m_started = 1'b0;

    always @(posedge clock) begin : model
        int          s;
        logic        valid;
        logic [31:0] ps, pv, nirr, npend, novf;
        logic        rise, lvl, chg, c, io, po;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_irr[k]  = '0;
                m_pend[k] = '0;
                m_ovf[k]  = '0;
            end
            for (int j = 0; j < 4; j++) hist[j] = '0;
            m_cfgp = '0;
            m_n    = 0;
        end else begin
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = pin;
            for (int k = 0; k < 2; k++) begin
                s     = (k == 0) ? 2 : 0;
                valid = (m_n >= s);
                ps    = valid ? hist[s] : 32'h0;
                pv    = (m_n > s) ? hist[s+1] : 32'hFFFF_FFFF;
                for (int i = 0; i < 32; i++) begin
                    rise = valid & ps[i] & ~pv[i];
                    lvl  = cfg[i];
                    chg  = cfg[i] ^ m_cfgp[i];
                    c    = clr[i];
                    io   = m_irr[k][i];
                    po   = m_pend[k][i];
                    if (c)        nirr[i] = 1'b0;
                    else if (frz) nirr[i] = io;
                    else if (lvl) nirr[i] = ps[i];
                    else          nirr[i] = io | rise | po;
                    if (lvl || chg)               npend[i] = 1'b0;
                    else if (rise && (frz || c))  npend[i] = 1'b1;
                    else if (!frz && !c)          npend[i] = 1'b0;
                    else                          npend[i] = po;
                    novf[i] = (!lvl & rise & io & !c) | (rise & po)
                            | (m_ovf[k][i] & ~oclr[i]);
                end
                m_irr[k]  = nirr;
                m_pend[k] = npend;
                m_ovf[k]  = novf;
            end
            m_cfgp = cfg;
            if (m_n < 8) m_n = m_n + 1;
        end
        m_started = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (m_started) begin
            check("a_irr", 32'(a_irr), m_irr[0] & 32'h0000_00FF);
            check("a_ovf", 32'(a_ovf), m_ovf[0] & 32'h0000_00FF);
            check("a_any", 32'(a_any), 32'(|m_irr[0][7:0]));
            check("b_irr", 32'(b_irr), m_irr[1] & 32'h0000_FFFF);
            check("b_ovf", 32'(b_ovf), m_ovf[1] & 32'h0000_FFFF);
            check("b_any", 32'(b_any), 32'(|m_irr[1][15:0]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        cfg   = '0;
        frz   = 1'b0;
        clr   = '0;
        oclr  = '0;
        pin   = '0;
        tick(3);
        check("rst_a_irr", 32'(a_irr), 32'h0);
        check("rst_a_ovf", 32'(a_ovf), 32'h0);
        check("rst_a_any", 32'(a_any), 32'h0);
        check("rst_b_irr", 32'(b_irr), 32'h0);

        // level mode on ch0: 3-clock latency on rise and fall
        cfg   = 32'h1;
        reset = 1'b0;
        tick(4);
        pin = 32'h1;
        tick(2);
        check("lvl_early", 32'(a_irr), 32'h0);
        tick(1);
        check("lvl_rise", 32'(a_irr), 32'h01);
        check("lvl_any", 32'(a_any), 32'h1);
        pin = 32'h0;
        tick(3);
        check("lvl_fall", 32'(a_irr), 32'h0);
        check("lvl_any0", 32'(a_any), 32'h0);

        // edge mode: pulse on pin5 is held until cleared
        cfg = 32'h0;
        pin = 32'h20;
        tick(1);
        pin = 32'h0;
        tick(2);
        check("edge_set", 32'(a_irr), 32'h20);
        tick(4);
        check("edge_hold", 32'(a_irr), 32'h20);
        clr = 32'h20;
        tick(1);
        clr = 32'h0;
        check("edge_clr", 32'(a_irr), 32'h0);

        // pin3 high through reset is not an edge
        pin   = 32'h08;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        check("hi_rst_a", 32'(a_irr), 32'h0);
        check("hi_rst_b", 32'(b_irr), 32'h0);
        pin = 32'h0;
        tick(3);
        pin = 32'h08;
        tick(3);
        check("hi_rst_edge", 32'(a_irr), 32'h08);
        clr = 32'hFFFF_FFFF;
        tick(1);
        clr = 32'h0;
        check("clr_all", 32'(a_irr), 32'h0);

        // freeze parks edge on pin7; release folds it in
        frz = 1'b1;
        pin = 32'h88;
        tick(5);
        check("frz_hold", 32'(a_irr), 32'h0);
        frz = 1'b0;
        tick(1);
        check("frz_release", 32'(a_irr), 32'h80);
        frz = 1'b1;
        clr = 32'h0000_00FF;
        tick(1);
        check("frz_clr", 32'(a_irr), 32'h0);
        clr = 32'h0;
        frz = 1'b0;
        tick(1);
        check("frz_after", 32'(a_irr), 32'h0);

        // overflow on second edge while IRR[2] set
        pin = 32'h0;
        tick(3);
        pin = 32'h04;
        tick(3);
        check("ovf_first", 32'(a_irr), 32'h04);
        check("ovf_none", 32'(a_ovf), 32'h0);
        pin = 32'h0;
        tick(2);
        pin = 32'h04;
        tick(3);
        check("ovf_set", 32'(a_ovf), 32'h04);
        oclr = 32'h04;
        tick(1);
        oclr = 32'h0;
        check("ovf_clr", 32'(a_ovf), 32'h0);
        clr = 32'h04;
        tick(1);
        clr = 32'h0;
        check("irr2_clr", 32'(a_irr), 32'h0);
        // edge coincident with clear[2]
        pin = 32'h0;
        tick(3);
        pin = 32'h04;
        tick(2);
        clr = 32'h04;
        tick(1);
        clr = 32'h0;
        check("coinc_0", 32'(a_irr), 32'h0);
        tick(1);
        check("coinc_1", 32'(a_irr), 32'h04);
        check("coinc_ovf", 32'(a_ovf), 32'h0);

        // 16 channels, no synchroniser
        clr  = 32'hFFFF_FFFF;
        oclr = 32'hFFFF_FFFF;
        tick(1);
        clr  = 32'h0;
        oclr = 32'h0;
        pin  = 32'h0;
        tick(1);
        pin = 32'h8000;
        tick(1);
        check("b_edge15", 32'(b_irr), 32'h8000);
        clr = 32'hFFFF_FFFF;
        tick(1);
        clr = 32'h0;
        pin = 32'h0;
        tick(1);
        frz = 1'b1;
        pin = 32'h8000;
        tick(1);
        cfg = 32'h8000;
        tick(1);
        cfg = 32'h0;
        tick(1);
        frz = 1'b0;
        tick(2);
        check("b_cfg_drop", 32'(b_irr), 32'h0);

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            pin  = pin ^ ($urandom & $urandom & $urandom);
            frz  = ($urandom_range(0, 7) == 0);
            clr  = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
            oclr = ($urandom_range(0, 5) == 0) ? ($urandom & $urandom) : 32'h0;
            if ($urandom_range(0, 49) == 0) cfg = $urandom;
            reset = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
